// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory bus arbiter.
//   arb_state_e : FSM state encoding (idle, access, wait, response)
//   owner_e     : requester IDs, CPU = 0, DMA = 1
//   RD_LAT_MIN/RD_LAT_MAX : legal range of the downstream read latency
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // Wait counter holds at most RD_LAT_MAX-2.
  localparam int unsigned WAIT_CNT_W = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and DMA requesters.
//   cpu_req_i, dma_req_i : pending requests
//   last_owner_i         : owner of the previous access; loses a tie
//   winner_o             : selected requester (meaningful when valid_o)
//   valid_o              : at least one request is pending
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   dma_req_i,
  input  owner_e last_owner_i,
  output owner_e winner_o,
  output logic   valid_o
);

  always_comb begin
    valid_o  = cpu_req_i | dma_req_i;
    winner_o = OWNER_CPU;
    if (cpu_req_i && dma_req_i) begin
      if (last_owner_i == OWNER_CPU) begin
        winner_o = OWNER_DMA;
      end
    end else if (dma_req_i) begin
      winner_o = OWNER_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a CPU and a DMA requester onto one downstream memory port.
// An access runs IDLE (grant) -> ACCESS (one-cycle strobe) -> [WAIT] -> RESP (done).
// Ports:
//   clk_i, rst_ni                      : clock, asynchronous active-low reset
//   cpu_*_i / cpu_*_o                  : CPU request, grant pulse, done pulse, read data
//   dma_*_i / dma_*_o                  : DMA/loader requester, same protocol
//   writeEn_o, addressIN_o, CPUdata_IN_o : downstream write strobe, address, write data
//   CPUdata_OUT_i                      : downstream read data, valid RD_LAT cycles after ACCESS
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the
// CPU has fixed priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [WIDTH-1:0] cpu_addr_i,
  input  logic [WIDTH-1:0] cpu_wdata_i,
  output logic             cpu_gnt_o,
  output logic             cpu_done_o,
  output logic [WIDTH-1:0] cpu_rdata_o,
  input  logic             dma_req_i,
  input  logic             dma_we_i,
  input  logic [WIDTH-1:0] dma_addr_i,
  input  logic [WIDTH-1:0] dma_wdata_i,
  output logic             dma_gnt_o,
  output logic             dma_done_o,
  output logic [WIDTH-1:0] dma_rdata_o,
  output logic             writeEn_o,
  output logic [WIDTH-1:0] addressIN_o,
  output logic [WIDTH-1:0] CPUdata_IN_o,
  input  logic [WIDTH-1:0] CPUdata_OUT_i
);

  // Extra WAIT cycles after ACCESS minus one (counter runs down to zero).
  localparam logic [WAIT_CNT_W-1:0] WaitInit =
      (RD_LAT >= 2) ? WAIT_CNT_W'(RD_LAT - 2) : '0;

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  we_q, we_d;
  logic [WIDTH-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  owner_e last_owner;
  owner_e winner;
  logic   pick_valid;
  logic   grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_q;

  // DMA counts as the previous owner out of reset so the CPU wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWNER_DMA;
    end else if (grant) begin
      last_q <= winner;
    end
  end

  assign last_owner = last_q;
`else
  // Pretending the DMA always owned last gives the CPU fixed priority.
  assign last_owner = OWNER_DMA;
`endif

  mem_arb_pick u_pick (
    .cpu_req_i    (cpu_req_i),
    .dma_req_i    (dma_req_i),
    .last_owner_i (last_owner),
    .winner_o     (winner),
    .valid_o      (pick_valid)
  );

  // Gated by rst_ni so no grant escapes while reset is held.
  assign grant = rst_ni && (state_q == StIdle) && pick_valid;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StAccess;
          owner_d = winner;
          if (winner == OWNER_DMA) begin
            we_d    = dma_we_i;
            addr_d  = dma_addr_i;
            wdata_d = dma_wdata_i;
          end else begin
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i;
            wdata_d = cpu_wdata_i;
          end
        end
      end
      StAccess: begin
        if (we_q || (RD_LAT <= 1)) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= OWNER_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request only changes on the edge into ACCESS, so it holds everywhere else.
  assign addressIN_o  = addr_q;
  assign CPUdata_IN_o = wdata_q;
  assign writeEn_o    = (state_q == StAccess) && we_q;

  assign cpu_gnt_o  = grant && (winner == OWNER_CPU);
  assign dma_gnt_o  = grant && (winner == OWNER_DMA);
  assign cpu_done_o = (state_q == StResp) && (owner_q == OWNER_CPU);
  assign dma_done_o = (state_q == StResp) && (owner_q == OWNER_DMA);

  // RESP lands exactly RD_LAT cycles after ACCESS, so read data passes straight through.
  assign cpu_rdata_o = (cpu_done_o && !we_q) ? CPUdata_OUT_i : '0;
  assign dma_rdata_o = (dma_done_o && !we_q) ? CPUdata_OUT_i : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (RD_LAT = 2, WIDTH = 32).
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned RL = 2;

  logic         clk_i  = 1'b0;
  logic         rst_ni = 1'b0;
  logic         cpu_req, cpu_we, cpu_gnt, cpu_done;
  logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic         dma_req, dma_we, dma_gnt, dma_done;
  logic [W-1:0] dma_addr, dma_wdata, dma_rdata;
  logic         wen;
  logic [W-1:0] addr_out, wdata_out, rdata_in;

  int unsigned cyc       = 0;
  int unsigned magic_cyc = 32'hFFFF_FFFF;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int unsigned wr_cnt    = 0;
  int unsigned wen_double = 0;
  logic        wen_prev  = 1'b0;

  typedef struct {
    owner_e       owner;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  mem_bus_arbiter #(
    .WIDTH  (W),
    .RD_LAT (RL)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cpu_req_i     (cpu_req),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_gnt_o     (cpu_gnt),
    .cpu_done_o    (cpu_done),
    .cpu_rdata_o   (cpu_rdata),
    .dma_req_i     (dma_req),
    .dma_we_i      (dma_we),
    .dma_addr_i    (dma_addr),
    .dma_wdata_i   (dma_wdata),
    .dma_gnt_o     (dma_gnt),
    .dma_done_o    (dma_done),
    .dma_rdata_o   (dma_rdata),
    .writeEn_o     (wen),
    .addressIN_o   (addr_out),
    .CPUdata_IN_o  (wdata_out),
    .CPUdata_OUT_i (rdata_in)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Downstream read data is tagged with the cycle number so a wrong sampling cycle shows up.
  assign rdata_in = (cyc == magic_cyc) ? 32'h1234_5678 : (32'hA500_0000 ^ cyc);

  always @(negedge clk_i) begin
    if (wen) begin
      wr_cnt++;
      if (wen_prev) wen_double++;
    end
    wen_prev = wen;
  end

  task automatic wait_gnt(input int budget, output owner_e who, output int unsigned c,
                          output bit both, output bit to);
    to = 1'b1; both = 1'b0; who = OWNER_CPU; c = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (cpu_gnt || dma_gnt) begin
        who  = dma_gnt ? OWNER_DMA : OWNER_CPU;
        both = cpu_gnt && dma_gnt;
        c    = cyc;
        to   = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output owner_e who, output int unsigned c,
                           output logic [W-1:0] rd, output logic [W-1:0] ord,
                           output bit both, output bit to);
    to = 1'b1; both = 1'b0; who = OWNER_CPU; c = 0; rd = '0; ord = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (cpu_done || dma_done) begin
        who  = dma_done ? OWNER_DMA : OWNER_CPU;
        both = cpu_done && dma_done;
        rd   = dma_done ? dma_rdata : cpu_rdata;
        ord  = dma_done ? cpu_rdata : dma_rdata;
        c    = cyc;
        to   = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h55; cpu_wdata = 32'h66;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h77; dma_wdata = 32'h88;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({cpu_gnt, cpu_done, dma_gnt, dma_done, wen} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000", {cpu_gnt, cpu_done, dma_gnt, dma_done, wen});
    end
    n_checks++;
    if (addr_out !== '0 || wdata_out !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h data %h want 0 0", addr_out, wdata_out);
    end
    n_checks++;
    if (cpu_rdata !== '0 || dma_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h want 0 0", cpu_rdata, dma_rdata);
    end
    cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_cpu_write();
    owner_e who; int unsigned start, c0, cd; bit both, to; logic [W-1:0] rd, ord; exp_t e;
    @(posedge clk_i); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0010; cpu_wdata = 32'hDEAD_BEEF;
    start = cyc;
    exp_q.push_back('{OWNER_CPU, 1'b1, 32'h0010, 32'h0});
    wait_gnt(4, who, c0, both, to);
    n_checks++;
    if (to || both || who !== OWNER_CPU || c0 !== start) begin
      n_fail++;
      $display("FAIL wr_gnt: got who %0d cyc %0d to %0d want 0 cyc %0d", who, c0, to, start);
    end
    @(negedge clk_i);
    e = exp_q.pop_front();
    n_checks++;
    if (wen !== 1'b1 || addr_out !== e.addr || wdata_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_access: got wen %b addr %h data %h want 1 %h deadbeef",
               wen, addr_out, wdata_out, e.addr);
    end
    wait_done(4, who, cd, rd, ord, both, to);
    n_checks++;
    if (to || both || who !== e.owner || cd !== c0 + 2) begin
      n_fail++;
      $display("FAIL wr_done: got who %0d cyc %0d to %0d want %0d cyc %0d",
               who, cd, to, e.owner, c0 + 2);
    end
    n_checks++;
    if (rd !== e.rdata || ord !== '0 || wen !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rdata: got rd %h other %h wen %b want 0 0 0", rd, ord, wen);
    end
    @(posedge clk_i); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_dma_read();
    owner_e who; int unsigned start, c0, cd; bit both, to; logic [W-1:0] rd, ord; exp_t e;
    @(posedge clk_i); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h4004; dma_wdata = 32'h0;
    start = cyc;
    exp_q.push_back('{OWNER_DMA, 1'b0, 32'h4004, 32'h1234_5678});
    wait_gnt(4, who, c0, both, to);
    magic_cyc = c0 + 1 + RL;
    n_checks++;
    if (to || both || who !== OWNER_DMA || c0 !== start) begin
      n_fail++;
      $display("FAIL rd_gnt: got who %0d cyc %0d to %0d want 1 cyc %0d", who, c0, to, start);
    end
    e = exp_q.pop_front();
    @(negedge clk_i);
    n_checks++;
    if (wen !== 1'b0 || addr_out !== e.addr) begin
      n_fail++;
      $display("FAIL rd_access: got wen %b addr %h want 0 %h", wen, addr_out, e.addr);
    end
    @(negedge clk_i);
    n_checks++;
    if (addr_out !== e.addr || dma_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_wait: got addr %h done %b want %h 0", addr_out, dma_done, e.addr);
    end
    wait_done(4, who, cd, rd, ord, both, to);
    n_checks++;
    if (to || both || who !== e.owner || cd !== c0 + 1 + RL) begin
      n_fail++;
      $display("FAIL rd_done: got who %0d cyc %0d to %0d want 1 cyc %0d",
               who, cd, to, c0 + 1 + RL);
    end
    n_checks++;
    if (rd !== e.rdata || ord !== '0) begin
      n_fail++;
      $display("FAIL rd_data: got %h other %h want %h 0", rd, ord, e.rdata);
    end
    @(posedge clk_i); #1;
    dma_req = 1'b0;
    magic_cyc = 32'hFFFF_FFFF;
  endtask

  task automatic test_contention();
    owner_e who, whod; int unsigned cg, cd, prev_cd; bit both, to;
    logic [W-1:0] rd, ord, want; exp_t e; owner_e order [4];
    prev_cd = 0;
    for (int i = 0; i < 4; i++) order[i] = OWNER_CPU;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    order[1] = OWNER_DMA;
    order[3] = OWNER_DMA;
`endif
    @(posedge clk_i); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0200;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{order[i], 1'b0, (order[i] == OWNER_DMA) ? 32'h0200 : 32'h0100, 32'h0});
    end
    for (int i = 0; i < 4; i++) begin
      wait_gnt(6, who, cg, both, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || both || who !== e.owner) begin
        n_fail++;
        $display("FAIL cont_gnt%0d: got who %0d to %0d both %0d want %0d",
                 i, who, to, both, e.owner);
      end
      if (i > 0) begin
        n_checks++;
        if (cg !== prev_cd + 1) begin
          n_fail++;
          $display("FAIL cont_rearb%0d: got gnt cyc %0d want %0d", i, cg, prev_cd + 1);
        end
      end
      @(negedge clk_i);
      n_checks++;
      if (addr_out !== e.addr || wen !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_addr%0d: got %h wen %b want %h 0", i, addr_out, wen, e.addr);
      end
      wait_done(6, whod, cd, rd, ord, both, to);
      want = 32'hA500_0000 ^ (cg + 1 + RL);
      n_checks++;
      if (to || both || whod !== e.owner || cd !== cg + 1 + RL || rd !== want || ord !== '0) begin
        n_fail++;
        $display("FAIL cont_done%0d: got who %0d cyc %0d rd %h other %h want %0d cyc %0d rd %h",
                 i, whod, cd, rd, ord, e.owner, cg + 1 + RL, want);
      end
      prev_cd = cd;
    end
    @(posedge clk_i); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic test_early_release();
    owner_e who; int unsigned start, c0, cd; bit both, to; logic [W-1:0] rd, ord;
    int unsigned extra;
    @(posedge clk_i); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0020; cpu_wdata = 32'h0BAD_F00D;
    start = cyc;
    wait_gnt(4, who, c0, both, to);
    n_checks++;
    if (to || who !== OWNER_CPU || c0 !== start) begin
      n_fail++;
      $display("FAIL rel_gnt: got who %0d cyc %0d to %0d want 0 cyc %0d", who, c0, to, start);
    end
    @(posedge clk_i); #1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'hFFFF; cpu_wdata = 32'h0;
    @(negedge clk_i);
    n_checks++;
    if (wen !== 1'b1 || addr_out !== 32'h0020 || wdata_out !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL rel_access: got wen %b addr %h data %h want 1 00000020 0badf00d",
               wen, addr_out, wdata_out);
    end
    wait_done(4, who, cd, rd, ord, both, to);
    n_checks++;
    if (to || who !== OWNER_CPU || cd !== c0 + 2 || rd !== '0) begin
      n_fail++;
      $display("FAIL rel_done: got who %0d cyc %0d rd %h to %0d want 0 cyc %0d rd 0",
               who, cd, rd, to, c0 + 2);
    end
    extra = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (cpu_gnt || dma_gnt || wen) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL rel_idle: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_access();
    owner_e who; int unsigned start, c0, cd; bit both, to; logic [W-1:0] rd, ord;
    int unsigned done_seen;
    @(posedge clk_i); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0030; cpu_wdata = 32'h0000_0077;
    wait_gnt(4, who, c0, both, to);
    @(posedge clk_i); #2;
    n_checks++;
    if (wen !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got wen %b want 1", wen);
    end
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (wen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: got wen %b want 0", wen);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    done_seen = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (cpu_done || dma_done) done_seen++;
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0040; dma_wdata = 32'h0000_0099;
    start = cyc;
    wait_gnt(4, who, c0, both, to);
    if (cpu_done || dma_done) done_seen++;
    n_checks++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL mid_nodone: got %0d done pulses want 0", done_seen);
    end
    n_checks++;
    if (to || who !== OWNER_DMA || c0 !== start) begin
      n_fail++;
      $display("FAIL mid_idle_gnt: got who %0d cyc %0d to %0d want 1 cyc %0d",
               who, c0, to, start);
    end
    @(negedge clk_i);
    n_checks++;
    if (wen !== 1'b1 || addr_out !== 32'h0040 || wdata_out !== 32'h0000_0099) begin
      n_fail++;
      $display("FAIL mid_next_access: got wen %b addr %h data %h want 1 00000040 00000099",
               wen, addr_out, wdata_out);
    end
    wait_done(4, who, cd, rd, ord, both, to);
    n_checks++;
    if (to || who !== OWNER_DMA || cd !== c0 + 2) begin
      n_fail++;
      $display("FAIL mid_next_done: got who %0d cyc %0d to %0d want 1 cyc %0d",
               who, cd, to, c0 + 2);
    end
    @(posedge clk_i); #1;
    dma_req = 1'b0; dma_we = 1'b0;
  endtask

  task automatic test_wen_pulse();
    @(posedge clk_i); #1;
    n_checks++;
    if (wen_double !== 0) begin
      n_fail++;
      $display("FAIL wen_single: got %0d multi-cycle strobes want 0", wen_double);
    end
    // Writes that reached a sampled ACCESS cycle: cpu write, early release, post-reset dma.
    n_checks++;
    if (wr_cnt !== 3) begin
      n_fail++;
      $display("FAIL wen_count: got %0d strobes want 3", wr_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_contention();
    test_early_release();
    test_reset_mid_access();
    test_wen_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data and address width of both requester ports and the downstream port.
REQ-002 SHALL have parameter RD_LAT, default 1, giving the downstream read latency in clk cycles; legal values are 1 to 4.
REQ-003 clk  input  1  single clock for all state; every register updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; resets all state immediately when low.
REQ-005 cpu_req  input  1  CPU access request; held high until cpu_done.
REQ-006 cpu_we  input  1  CPU write strobe, qualified by cpu_req.
REQ-007 cpu_addr, cpu_wdata  input  WIDTH each  CPU address and write data.
REQ-008 cpu_gnt  output  1  one-cycle pulse when the CPU request is accepted.
REQ-009 cpu_done  output  1  one-cycle pulse when the CPU access completes.
REQ-010 cpu_rdata  output  WIDTH  CPU read data, valid while cpu_done is high.
REQ-011 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata  same directions and widths as the cpu_* ports; DMA/loader requester.
REQ-012 writeEn  output  1  downstream write enable to the memory controller.
REQ-013 addressIN  output  WIDTH  downstream address.
REQ-014 CPUdata_IN  output  WIDTH  downstream write data.
REQ-015 CPUdata_OUT  input  WIDTH  downstream read data.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, WAIT and RESP.
REQ-017 IDLE: if any request is high, SHALL select a winner, latch its we/addr/wdata and owner ID, pulse its gnt in the same cycle, and go to ACCESS next cycle.
REQ-018 ACCESS: for exactly one cycle, SHALL drive addressIN and CPUdata_IN from the latched values and drive writeEn = latched we.
REQ-019 SHALL assert writeEn only in ACCESS; it SHALL never be asserted for more than one cycle per access.
REQ-020 After ACCESS, a write SHALL go to RESP.
REQ-021 After ACCESS, a read SHALL go to WAIT, hold the latched address for RD_LAT-1 further cycles, then go to RESP.
REQ-022 RESP: SHALL pulse the owner's done and present the owner's rdata.
REQ-023 On a read, rdata SHALL equal CPUdata_OUT sampled RD_LAT cycles after ACCESS.
REQ-024 On a write, rdata SHALL be 0.
REQ-025 From RESP, the FSM SHALL return to IDLE; arbitration for the next access happens in that IDLE cycle.
REQ-026 Write latency SHALL be gnt to done = 2 cycles; read latency SHALL be 2+RD_LAT-1 cycles.
REQ-027 When both requests are high in IDLE, the winner SHALL be chosen per REQ-036/REQ-037.
REQ-028 A requester dropping req after gnt SHALL NOT abort the access; it completes and done still pulses.
REQ-029 A req held high through its own done SHALL be treated as a new request at the next IDLE.
REQ-030 Changes on requester addr/wdata/we after gnt SHALL NOT affect the access in flight.
REQ-031 The non-owner's gnt, done and rdata SHALL stay 0 for the whole access.
REQ-032 Outside ACCESS and WAIT, addressIN and CPUdata_IN SHALL hold their last values; writeEn SHALL be 0.

Reset
REQ-033 On reset low, SHALL force state IDLE and drive all gnt/done/writeEn outputs, all rdata outputs, addressIN and CPUdata_IN to 0.
REQ-034 SHALL set the round-robin pointer so the DMA is the last owner, making the CPU win first after reset.
REQ-035 A reset asserted during ACCESS SHALL drop writeEn asynchronously; no done SHALL be issued for the aborted access.

Configuration
REQ-036 With macro MEM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the requester that was not the last owner SHALL win, and the last-owner pointer SHALL update at every gnt.
REQ-037 Without MEM_ARB_ROUND_ROBIN_EN, the CPU SHALL always win simultaneous requests (fixed priority) and no last-owner register SHALL exist.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the FSM state encoding, the owner IDs (OWNER_CPU = 0, OWNER_DMA = 1) and the RD_LAT bounds.
REQ-039 Winner selection SHALL be a sub-module mem_arb_pick (inputs: two reqs and last owner; outputs: winner and valid), combinational, instantiated once.

Verification
REQ-040 Reset, CPU write: reset then cpu_req=1, we=1, addr=0x0010, wdata=0xDEADBEEF -> cpu_gnt pulses in cycle 0; writeEn=1 with addressIN=0x0010 in cycle 1; cpu_done in cycle 2.
REQ-041 Read latency: RD_LAT=2, dma read of addr 0x4004 with CPUdata_OUT=0x12345678 two cycles after ACCESS -> dma_done with dma_rdata=0x12345678 at gnt+3.
REQ-042 Contention: both reqs held high for 4 accesses -> with MEM_ARB_ROUND_ROBIN_EN, grant order CPU, DMA, CPU, DMA; without it, CPU four times.
REQ-043 Early release: cpu_req dropped and addr changed to 0xFFFF the cycle after gnt -> access to the original address completes and cpu_done still pulses.
REQ-044 Reset mid-access: reset low during ACCESS of a write -> writeEn falls without waiting for clk, no done pulse, FSM in IDLE after release.
